alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 55 +++++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/rr_arb2.sv | 34 +++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for alu_arbiter: opcodes, FSM state, counter width and the ALU datapath function.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    OpAnd   = 3'd0,
    OpOr    = 3'd1,
    OpXor   = 3'd2,
    OpNor   = 3'd3,
    OpAdd   = 3'd4,
    OpSub   = 3'd5,
    OpPassA = 3'd6,
    OpNotA  = 3'd7
  } opcode_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  localparam int unsigned OpCountWidth = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        carry;
  } alu_res_t;

  function automatic alu_res_t alu_compute(opcode_e op, logic [31:0] a, logic [31:0] b);
    alu_res_t    r;
    logic [32:0] sum;
    r   = '0;
    sum = '0;
    unique case (op)
      OpAnd:   r.data = a & b;
      OpOr:    r.data = a | b;
      OpXor:   r.data = a ^ b;
      OpNor:   r.data = ~(a | b);
      OpAdd: begin
        sum     = {1'b0, a} + {1'b0, b};
        r.data  = sum[31:0];
        r.carry = sum[32];
      end
      OpSub: begin
        // Bit 32 is the no-borrow flag.
        sum     = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.data  = sum[31:0];
        r.carry = sum[32];
      end
      OpPassA: r.data = a;
      OpNotA:  r.data = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/result bus of alu_arbiter; slave is the arbiter, master is the requester/consumer side.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2:0]              req_op0;
  logic [2:0]              req_op1;
  logic [31:0]             req_a0;
  logic [31:0]             req_a1;
  logic [31:0]             req_b0;
  logic [31:0]             req_b1;
  logic                    res_valid;
  logic                    res_ready;
  logic [31:0]             res_data;
  logic                    res_id;
  logic                    res_carry;
  logic                    res_zero;
  logic                    res_ones;
  logic [OpCountWidth-1:0] op_count;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, res_ready,
    output req_ready, res_valid, res_data, res_id, res_carry, res_zero, res_ones, op_count
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_carry, res_zero, res_ones, op_count
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only when upd is set.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU with round-robin arbitration and a one-entry result register.
// Define ALU_ARBITER_FLAGS_EN to build the registered res_zero/res_ones flags.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  state_e                  state_q, state_d;
  logic                    can_grant;
  logic                    accept;
  logic                    res_valid;
  logic [1:0]              gnt;
  logic                    sel;
  logic [2:0]              op_sel;
  logic [31:0]             a_sel, b_sel;
  alu_res_t                alu_res;
  logic [31:0]             data_q;
  logic                    id_q;
  logic                    carry_q;
  logic [OpCountWidth-1:0] count_q;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req_valid),
    .en  (can_grant),
    .upd (accept),
    .gnt (gnt)
  );

  assign accept        = |(gnt & bus.req_valid);
  assign bus.req_ready = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (bus.res_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    can_grant = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      StEmpty: can_grant = !rst;
      StFull: begin
        can_grant = !rst && bus.res_ready;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign sel     = gnt[1];
  assign op_sel  = sel ? bus.req_op1 : bus.req_op0;
  assign a_sel   = sel ? bus.req_a1  : bus.req_a0;
  assign b_sel   = sel ? bus.req_b1  : bus.req_b0;
  assign alu_res = alu_compute(opcode_e'(op_sel), a_sel, b_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      data_q  <= alu_res.data;
      id_q    <= sel;
      carry_q <= alu_res.carry;
    end
  end

`ifdef ALU_ARBITER_FLAGS_EN
  logic zero_q, ones_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ones_q <= 1'b0;
    end else if (accept) begin
      zero_q <= &(~alu_res.data);
      ones_q <= &alu_res.data;
    end
  end

  assign bus.res_zero = zero_q;
  assign bus.res_ones = ones_q;
`else
  assign bus.res_zero = 1'b0;
  assign bus.res_ones = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept && (count_q != {OpCountWidth{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.res_valid = res_valid;
  assign bus.res_data  = data_q;
  assign bus.res_id    = id_q;
  assign bus.res_carry = carry_q;
  assign bus.op_count  = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner sequences, random vs model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a held result and an arbitration history.
  bit          m_full;
  int          m_last;
  logic [31:0] m_data;
  int          m_id;
  bit          m_carry;
  bit          m_zero;
  bit          m_ones;
  int          m_count;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        c;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_gnt();
    if (rst || (m_full && !bus.res_ready)) return -1;
    if (bus.req_valid == 2'b11) return 1 - m_last;
    if (bus.req_valid[0]) return 0;
    if (bus.req_valid[1]) return 1;
    return -1;
  endfunction

  function automatic void model_alu(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] d, output bit c);
    longint unsigned s;
    c = 1'b0;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: d = a ^ b;
      3'd3: d = ~(a | b);
      3'd4: begin
        s = longint'(a) + longint'(b);
        d = s[31:0];
        c = s[32];
      end
      3'd5: begin
        d = a - b;
        c = (a >= b);
      end
      3'd6: d = a;
      default: d = ~a;
    endcase
  endfunction

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    int          g;
    logic [31:0] d;
    bit          c;
    #1;
    g = exp_gnt();
    chk("req_ready", {30'd0, bus.req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    chk("res_valid", {31'd0, bus.res_valid}, {31'd0, m_full});
    chk("res_data", bus.res_data, m_data);
    chk("res_id", {31'd0, bus.res_id}, m_id);
    chk("res_carry", {31'd0, bus.res_carry}, {31'd0, m_carry});
    chk("res_zero", {31'd0, bus.res_zero}, {31'd0, m_zero});
    chk("res_ones", {31'd0, bus.res_ones}, {31'd0, m_ones});
    chk("op_count", {16'd0, bus.op_count}, m_count);
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_last = 1; m_data = '0; m_id = 0; m_carry = 0;
      m_zero = 0; m_ones = 0; m_count = 0;
    end else if (g >= 0) begin
      if (g == 0) model_alu(bus.req_op0, bus.req_a0, bus.req_b0, d, c);
      else        model_alu(bus.req_op1, bus.req_a1, bus.req_b1, d, c);
      m_data  = d;
      m_carry = c;
      m_id    = g;
      m_last  = g;
      m_full  = 1;
`ifdef ALU_ARBITER_FLAGS_EN
      m_zero  = (d == 32'd0);
      m_ones  = (d == 32'hFFFF_FFFF);
`endif
      if (m_count < 65535) m_count++;
    end else if (m_full && bus.res_ready) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00; bus.res_ready = 1'b1;
    bus.req_op0 = '0; bus.req_op1 = '0;
    bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
    m_full = 0; m_last = 1; m_data = '0; m_id = 0; m_carry = 0;
    m_zero = 0; m_ones = 0; m_count = 0;

    tbl[0] = '{3'd4, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
    tbl[1] = '{3'd5, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0};
    tbl[2] = '{3'd3, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    tbl[4] = '{3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
    tbl[5] = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    tbl[6] = '{3'd6, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
    tbl[7] = '{3'd7, 32'h1234_5678, 32'h0,         32'hEDCB_A987, 1'b0};
    tbl[8] = '{3'd5, 32'd7,         32'd5,         32'd2,         1'b1};
    tbl[9] = '{3'd4, 32'd1,         32'd2,         32'd3,         1'b0};

    @(negedge clk);
    do_reset();
    chk("reset_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("reset_count", {16'd0, bus.op_count}, 32'd0);

    // Directed vectors, one transfer each through requester 0.
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 2'b01;
      bus.req_op0 = tbl[i].op; bus.req_a0 = tbl[i].a; bus.req_b0 = tbl[i].b;
      bus.res_ready = 1'b1;
      tick();
      bus.req_valid = 2'b00;
      #1;
      chk("vec_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("vec_data", bus.res_data, tbl[i].d);
      chk("vec_carry", {31'd0, bus.res_carry}, {31'd0, tbl[i].c});
      chk("vec_id", {31'd0, bus.res_id}, 32'd0);
      chk("vec_count", {16'd0, bus.op_count}, i + 1);
`ifdef ALU_ARBITER_FLAGS_EN
      chk("vec_zero", {31'd0, bus.res_zero}, {31'd0, (tbl[i].d == 32'd0)});
      chk("vec_ones", {31'd0, bus.res_ones}, {31'd0, (tbl[i].d == 32'hFFFF_FFFF)});
`else
      chk("vec_zero", {31'd0, bus.res_zero}, 32'd0);
      chk("vec_ones", {31'd0, bus.res_ones}, 32'd0);
`endif
      tick();
    end

    // Both requesters always valid: grants alternate starting at 0.
    do_reset();
    bus.req_op0 = 3'd6; bus.req_a0 = 32'hA0;
    bus.req_op1 = 3'd6; bus.req_a1 = 32'hA1;
    bus.req_valid = 2'b11; bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("alt_gnt", {30'd0, bus.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end

    // Hold with res_ready low, then next grant goes to the other requester.
    do_reset();
    bus.req_valid = 2'b01; bus.res_ready = 1'b1;
    tick();
    bus.req_valid = 2'b11; bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.res_ready = 1'b1;
    #1;
    chk("hold_next_gnt", {30'd0, bus.req_ready}, 32'd2);
    tick();

    // Reset while full with both requesters valid.
    bus.req_valid = 2'b11; bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_count", {16'd0, bus.op_count}, 32'd0);
    chk("rst_first_gnt", {30'd0, bus.req_ready}, 32'd1);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      bus.req_valid = 2'($urandom);
      bus.res_ready = ($urandom_range(3) != 0);
      bus.req_op0 = 3'($urandom); bus.req_op1 = 3'($urandom);
      bus.req_a0 = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.req_b0 = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
      bus.req_a1 = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
      bus.req_b1 = ($urandom_range(7) == 0) ? bus.req_a1 : $urandom;
      tick();
    end
    rst = 1'b0;

    // Counter saturation.
    do_reset();
    bus.req_valid = 2'b11; bus.res_ready = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    chk("cnt_fffe", {16'd0, bus.op_count}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) tick();
    chk("cnt_sat", {16'd0, bus.op_count}, 32'h0000_FFFF);
    bus.req_valid = 2'b00;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
